bip_mc_core: RTL and testbench

- Parametrised multicycle successor to the single-cycle BIP II processor top.
- Adds ready/ack handshakes on the instruction and data memories, so wait-state memories can stall the core.
- Adds CALL/RET with a hardware return stack of configurable depth, plus an explicit halt state.
- Sits between the instruction ROM and data RAM wrappers at SoC top level.

---
 rtl/bip_mc_pkg.sv | 33 +++
 rtl/bip_mc_return_stack.sv | 50 +++++
 rtl/bip_mc_core.sv | 179 +++++++++++++++++
 tb/tb_bip_mc_core.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_mc_pkg.sv
// Shared types for the BIP multicycle core: opcode encoding and FSM states.
package bip_mc_pkg;

    localparam int unsigned OPCODE_WIDTH = 5;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_HLT  = 5'b00000,
        OP_STO  = 5'b00001,
        OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110,
        OP_SUBI = 5'b00111,
        OP_BEQ  = 5'b01000,
        OP_BNE  = 5'b01001,
        OP_BGT  = 5'b01010,
        OP_BGE  = 5'b01011,
        OP_BLT  = 5'b01100,
        OP_BLE  = 5'b01101,
        OP_JMP  = 5'b01110,
        OP_CALL = 5'b01111,
        OP_RET  = 5'b10000
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

endpackage

// File: rtl/bip_mc_return_stack.sv
// Return-address LIFO for CALL/RET; callers must not push when full or pop when empty.
module bip_mc_return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_in,
    input  logic             pop_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full_out,
    output logic             empty_out
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    sp_q, sp_d;
    logic [PW-1:0]    top;

    assign top       = sp_q - 1'b1;
    assign data_out  = mem_q[top[IW-1:0]];
    assign full_out  = (sp_q == PW'(DEPTH));
    assign empty_out = (sp_q == '0);

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        if (push_in) begin
            mem_d[sp_q[IW-1:0]] = data_in;
            sp_d = sp_q + 1'b1;
        end else if (pop_in) begin
            sp_d = sp_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sp_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            sp_q  <= sp_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/bip_mc_core.sv
// Multicycle BIP core: FETCH/EXEC/MEM/HALT FSM with req/ack memories and a return stack.
module bip_mc_core
    import bip_mc_pkg::*;
#(
    parameter int unsigned OPERAND_ADDRESS_WIDTH  = 11,
    parameter int unsigned INSTRUCTION_DATA_WIDTH = 16,
    parameter int unsigned STACK_DEPTH            = 4
) (
    input  logic                              clock_in,
    input  logic                              reset_in,
    output logic                              instruction_req_out,
    input  logic                              instruction_ack_in,
    output logic [OPERAND_ADDRESS_WIDTH-1:0]  instruction_address_out,
    input  logic [INSTRUCTION_DATA_WIDTH-1:0] instruction_in,
    output logic                              data_req_out,
    input  logic                              data_ack_in,
    output logic                              data_memory_wr_out,
    output logic [OPERAND_ADDRESS_WIDTH-1:0]  data_address_out,
    output logic [INSTRUCTION_DATA_WIDTH-1:0] data_out,
    input  logic [INSTRUCTION_DATA_WIDTH-1:0] data_in,
    output logic                              halted_out,
    output logic                              stack_error_out
);

    localparam int unsigned AW = OPERAND_ADDRESS_WIDTH;
    localparam int unsigned DW = INSTRUCTION_DATA_WIDTH;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   ir_q, ir_d;
    logic            z_q, z_d;
    logic            n_q, n_d;
    logic            err_q, err_d;

    opcode_t         opcode;
    logic [AW-1:0]   operand;
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   ret_addr;
    logic [DW-1:0]   imm;
    logic [DW-1:0]   result;
    logic            acc_we;
    logic            taken;
    logic            push, pop, full, empty;

    assign opcode  = opcode_t'(ir_q[DW-1 -: OPCODE_WIDTH]);
    assign operand = ir_q[AW-1:0];
    assign imm     = {{(DW-AW){operand[AW-1]}}, operand};
    assign pc_inc  = pc_q + 1'b1;

    assign instruction_req_out     = (state_q == ST_FETCH);
    assign instruction_address_out = pc_q;
    assign data_req_out            = (state_q == ST_MEM);
    assign data_memory_wr_out      = (state_q == ST_MEM) && (opcode == OP_STO);
    assign data_address_out        = operand;
    assign data_out                = acc_q;
    assign halted_out              = (state_q == ST_HALT);
    assign stack_error_out         = err_q;

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = z_q;
            OP_BNE:  taken = !z_q;
            OP_BGT:  taken = !z_q && !n_q;
            OP_BGE:  taken = !n_q;
            OP_BLT:  taken = n_q;
            OP_BLE:  taken = n_q || z_q;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        err_d   = err_q;
        acc_we  = 1'b0;
        result  = acc_q;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (instruction_ack_in) begin
                    ir_d    = instruction_in;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_HLT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    OP_STO, OP_LD, OP_ADD, OP_SUB: begin
                        pc_d    = pc_q;
                        state_d = ST_MEM;
                    end
                    OP_LDI:  begin acc_we = 1'b1; result = imm;         end
                    OP_ADDI: begin acc_we = 1'b1; result = acc_q + imm; end
                    OP_SUBI: begin acc_we = 1'b1; result = acc_q - imm; end
                    OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
                        if (taken) pc_d = operand;
                    end
                    // Overflowing CALL still jumps; only the push is dropped.
                    OP_CALL: begin
                        if (full) err_d = 1'b1;
                        else      push  = 1'b1;
                        pc_d = operand;
                    end
                    OP_RET: begin
                        if (empty) begin
                            err_d = 1'b1;
                        end else begin
                            pop  = 1'b1;
                            pc_d = ret_addr;
                        end
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (data_ack_in) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                    case (opcode)
                        OP_LD:  begin acc_we = 1'b1; result = data_in;         end
                        OP_ADD: begin acc_we = 1'b1; result = acc_q + data_in; end
                        OP_SUB: begin acc_we = 1'b1; result = acc_q - data_in; end
                        default: ;
                    endcase
                end
            end
            ST_HALT: ;
        endcase

        acc_d = acc_we ? result : acc_q;
        z_d   = acc_we ? (result == '0) : z_q;
        n_d   = acc_we ? result[DW-1] : n_q;
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end

    bip_mc_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (AW)
    ) u_return_stack (
        .clk_in    (clock_in),
        .rst_in    (reset_in),
        .push_in   (push),
        .pop_in    (pop),
        .data_in   (pc_inc),
        .data_out  (ret_addr),
        .full_out  (full),
        .empty_out (empty)
    );

endmodule

// File: tb/tb_bip_mc_core.sv
// Directed bench for bip_mc_core: table of small programs plus handshake/reset corner sequences.
module tb_bip_mc_core;

    localparam logic [4:0] B_HLT = 5'b00000, B_STO = 5'b00001, B_LD = 5'b00010, B_LDI = 5'b00011;
    localparam logic [4:0] B_ADD = 5'b00100, B_ADDI = 5'b00101, B_SUB = 5'b00110, B_SUBI = 5'b00111;
    localparam logic [4:0] B_BEQ = 5'b01000, B_BNE = 5'b01001, B_BGT = 5'b01010, B_BGE = 5'b01011;
    localparam logic [4:0] B_BLT = 5'b01100, B_BLE = 5'b01101, B_JMP = 5'b01110, B_CALL = 5'b01111;
    localparam logic [4:0] B_RET = 5'b10000, B_NOP = 5'b10001;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        instruction_req_out, instruction_ack_in = 1'b0;
    logic [10:0] instruction_address_out;
    logic [15:0] instruction_in = '0;
    logic        data_req_out, data_ack_in = 1'b0, data_memory_wr_out;
    logic [10:0] data_address_out;
    logic [15:0] data_out, data_in = '0;
    logic        halted_out, stack_error_out;

    always #5 clk = ~clk;

    bip_mc_core #(
        .OPERAND_ADDRESS_WIDTH  (11),
        .INSTRUCTION_DATA_WIDTH (16),
        .STACK_DEPTH            (4)
    ) dut (
        .clock_in                (clk),
        .reset_in                (reset_in),
        .instruction_req_out     (instruction_req_out),
        .instruction_ack_in      (instruction_ack_in),
        .instruction_address_out (instruction_address_out),
        .instruction_in          (instruction_in),
        .data_req_out            (data_req_out),
        .data_ack_in             (data_ack_in),
        .data_memory_wr_out      (data_memory_wr_out),
        .data_address_out        (data_address_out),
        .data_out                (data_out),
        .data_in                 (data_in),
        .halted_out              (halted_out),
        .stack_error_out         (stack_error_out)
    );

    // Memory models: ack after iwait/dwait extra cycles of a held request.
    logic [15:0] imem [2048];
    logic [15:0] dmem [2048];
    int unsigned iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
    logic        dack = 1'b0, late_ack = 1'b0;
    logic [10:0] daddr0 = '0, last_addr = '0;
    logic        addr_moved = 1'b0, last_wr = 1'b0;
    logic [15:0] last_data = '0;
    int unsigned hold_min = 0, hold_max = 0;

    always @(negedge clk) begin
        if (instruction_req_out) begin
            icnt++;
            if (icnt > iwait) begin
                instruction_ack_in = 1'b1;
                instruction_in     = imem[instruction_address_out];
                icnt = 0;
            end else begin
                instruction_ack_in = 1'b0;
            end
        end else begin
            instruction_ack_in = 1'b0;
            icnt = 0;
        end
        if (data_req_out) begin
            dcnt++;
            if (dcnt == 1) daddr0 = data_address_out;
            else if (data_address_out != daddr0) addr_moved = 1'b1;
            if (dcnt > dwait) begin
                dack    = 1'b1;
                data_in = dmem[data_address_out];
                if (data_memory_wr_out) dmem[data_address_out] = data_out;
                last_addr = data_address_out;
                last_wr   = data_memory_wr_out;
                last_data = data_out;
                if (hold_min == 0 || dcnt < hold_min) hold_min = dcnt;
                if (dcnt > hold_max) hold_max = dcnt;
                dcnt = 0;
            end else begin
                dack = 1'b0;
            end
        end else begin
            dack = 1'b0;
            dcnt = 0;
        end
        data_ack_in = dack | late_ack;
    end

    int unsigned errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] opd);
        return {op, opd};
    endfunction

    task automatic clear_mems();
        for (int i = 0; i < 2048; i++) begin
            imem[i] = enc(B_HLT, 11'h000);
            dmem[i] = 16'h1000 + 16'(i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_in = 1'b1;
        @(posedge clk);
        #1;
        icnt = 0; dcnt = 0; addr_moved = 1'b0; hold_min = 0; hold_max = 0;
        @(posedge clk);
        @(negedge clk);
        reset_in = 1'b0;
    endtask

    task automatic wait_halt(input string name, output int unsigned cyc);
        cyc = 0;
        while (!halted_out && cyc < 300) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check({name, "_halted"}, 32'(halted_out), 32'd1);
    endtask

    typedef struct packed {
        logic [2:0]       n;
        logic [5:0][10:0] addr;
        logic [5:0][15:0] ins;
        logic [15:0]      exp_acc;
        logic [10:0]      exp_pc;
        logic             exp_err;
    } vec_t;

    vec_t        vecs [24];
    int unsigned nvec = 0;

    task automatic vb();
        vecs[nvec] = '0;
        nvec++;
    endtask

    task automatic vi(input logic [10:0] a, input logic [15:0] ins);
        vecs[nvec-1].addr[vecs[nvec-1].n] = a;
        vecs[nvec-1].ins[vecs[nvec-1].n]  = ins;
        vecs[nvec-1].n = vecs[nvec-1].n + 3'd1;
    endtask

    task automatic ve(input logic [15:0] acc, input logic [10:0] pc, input logic err);
        vecs[nvec-1].exp_acc = acc;
        vecs[nvec-1].exp_pc  = pc;
        vecs[nvec-1].exp_err = err;
    endtask

    initial begin
        int unsigned cyc;
        int unsigned reqs;

        vb(); vi(0, enc(B_LDI, 11'd5)); vi(1, enc(B_ADDI, 11'h7F9)); ve(16'hFFFE, 11'd2, 0);
        vb(); vi(0, enc(B_LDI, 11'd3)); vi(1, enc(B_SUBI, 11'd3)); vi(2, enc(B_BEQ, 11'h020)); ve(16'h0000, 11'h020, 0);
        vb(); vi(0, enc(B_LDI, 11'd4)); vi(1, enc(B_SUBI, 11'd3)); vi(2, enc(B_BEQ, 11'h020)); ve(16'h0001, 11'd3, 0);
        vb(); vi(0, enc(B_LDI, 11'h7FF)); vi(1, enc(B_BLT, 11'h030)); ve(16'hFFFF, 11'h030, 0);
        vb(); vi(0, enc(B_LDI, 11'h7FF)); vi(1, enc(B_BGE, 11'h030)); ve(16'hFFFF, 11'd2, 0);
        vb(); vi(0, enc(B_LDI, 11'd0)); vi(1, enc(B_BGT, 11'h030)); ve(16'h0000, 11'd2, 0);
        vb(); vi(0, enc(B_LDI, 11'd1)); vi(1, enc(B_BGT, 11'h030)); ve(16'h0001, 11'h030, 0);
        vb(); vi(0, enc(B_LDI, 11'd0)); vi(1, enc(B_BLE, 11'h031)); ve(16'h0000, 11'h031, 0);
        vb(); vi(0, enc(B_LDI, 11'd0)); vi(1, enc(B_BNE, 11'h031)); ve(16'h0000, 11'd2, 0);
        vb(); vi(0, enc(B_LDI, 11'd2)); vi(1, enc(B_BNE, 11'h031)); ve(16'h0002, 11'h031, 0);
        vb(); vi(0, enc(B_JMP, 11'd5)); vi(5, enc(B_CALL, 11'h040)); vi(6, enc(B_LDI, 11'd9));
              vi(11'h040, enc(B_LDI, 11'd7)); vi(11'h041, enc(B_RET, 11'd0)); ve(16'h0009, 11'd7, 0);
        vb(); vi(0, enc(B_RET, 11'd0)); ve(16'h0000, 11'd1, 1);
        vb(); vi(0, enc(B_CALL, 11'h010)); vi(11'h010, enc(B_CALL, 11'h020)); vi(11'h020, enc(B_CALL, 11'h030));
              vi(11'h030, enc(B_CALL, 11'h040)); ve(16'h0000, 11'h040, 0);
        vb(); vi(0, enc(B_CALL, 11'h010)); vi(11'h010, enc(B_CALL, 11'h020)); vi(11'h020, enc(B_CALL, 11'h030));
              vi(11'h030, enc(B_CALL, 11'h040)); vi(11'h040, enc(B_CALL, 11'h050)); ve(16'h0000, 11'h050, 1);
        vb(); vi(0, enc(B_LD, 11'h010)); vi(1, enc(B_ADD, 11'h011)); vi(2, enc(B_SUB, 11'h012)); ve(16'h100F, 11'd3, 0);
        vb(); vi(0, enc(B_LDI, 11'd0)); vi(1, enc(B_STO, 11'h005)); vi(2, enc(B_BEQ, 11'h022)); ve(16'h0000, 11'h022, 0);
        vb(); vi(0, enc(B_NOP, 11'h123)); vi(1, enc(B_LDI, 11'd2)); ve(16'h0002, 11'd2, 0);
        vb(); vi(0, enc(B_BNE, 11'h7FF)); vi(11'h7FF, enc(B_LDI, 11'd0)); ve(16'h0000, 11'd1, 0);
        vb(); vi(0, enc(B_LDI, 11'h7FF)); vi(1, enc(B_CALL, 11'h010)); vi(11'h010, enc(B_RET, 11'd0));
              vi(2, enc(B_BLT, 11'h033)); ve(16'hFFFF, 11'h033, 0);
        vb(); vi(0, enc(B_LDI, 11'h7FF)); vi(1, enc(B_ADDI, 11'd1)); vi(2, enc(B_BEQ, 11'h024)); ve(16'h0000, 11'h024, 0);

        // Reset state
        clear_mems();
        do_reset();
        check("rst_pc", 32'(instruction_address_out), 32'h0);
        check("rst_ireq", 32'(instruction_req_out), 32'h1);
        check("rst_dreq", 32'(data_req_out), 32'h0);
        check("rst_acc", 32'(data_out), 32'h0);
        check("rst_err", 32'(stack_error_out), 32'h0);

        for (int i = 0; i < int'(nvec); i++) begin
            clear_mems();
            for (int j = 0; j < int'(vecs[i].n); j++) imem[vecs[i].addr[j]] = vecs[i].ins[j];
            iwait = 32'(i % 3);
            dwait = 32'(i % 2);
            do_reset();
            wait_halt($sformatf("v%0d", i), cyc);
            check($sformatf("v%0d_acc", i), 32'(data_out), 32'(vecs[i].exp_acc));
            check($sformatf("v%0d_pc", i), 32'(instruction_address_out), 32'(vecs[i].exp_pc));
            check($sformatf("v%0d_err", i), 32'(stack_error_out), 32'(vecs[i].exp_err));
            if (i == 0) check("v0_halt_cycles", cyc, 32'd6);
        end

        // Data wait states: LD then STO with 3 wait states each
        clear_mems();
        dmem[11'h010] = 16'h1234;
        imem[0] = enc(B_LD, 11'h010);
        imem[1] = enc(B_STO, 11'h011);
        iwait = 0;
        dwait = 3;
        do_reset();
        wait_halt("ws", cyc);
        check("ws_mem", 32'(dmem[11'h011]), 32'h1234);
        check("ws_wr", 32'(last_wr), 32'h1);
        check("ws_addr", 32'(last_addr), 32'h011);
        check("ws_data", 32'(last_data), 32'h1234);
        check("ws_hold_min", hold_min, 32'd4);
        check("ws_hold_max", hold_max, 32'd4);
        check("ws_addr_stable", 32'(addr_moved), 32'h0);

        // HALT issues no further requests
        reqs = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (instruction_req_out || data_req_out) reqs++;
        end
        check("halt_no_req", reqs, 32'd0);

        // Reset in the middle of a data access, with a stray ack right after
        clear_mems();
        imem[0] = enc(B_LD, 11'h010);
        dwait = 20;
        do_reset();
        cyc = 0;
        while (!data_req_out && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mr_dreq_seen", 32'(data_req_out), 32'h1);
        reset_in = 1'b1;
        imem[0] = enc(B_LDI, 11'd6);
        @(posedge clk);
        #1;
        reset_in = 1'b0;
        late_ack = 1'b1;
        check("mr_pc", 32'(instruction_address_out), 32'h0);
        check("mr_ireq", 32'(instruction_req_out), 32'h1);
        check("mr_dreq", 32'(data_req_out), 32'h0);
        check("mr_acc", 32'(data_out), 32'h0);
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        dwait = 0;
        @(negedge clk);
        wait_halt("mr", cyc);
        check("mr_acc_final", 32'(data_out), 32'h0006);
        check("mr_pc_final", 32'(instruction_address_out), 32'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
